key_search_ctrl: RTL and testbench

- Brute-force key search controller; sits directly upstream of the RC4 decode-with-key stage.
- Drives that stage's secret_key and start inputs, waits for its done, then reads the decrypted-message RAM and checks every byte.
- Increments the key until a fully valid message is found or the key range is exhausted.
- Results go to the top level for LEDR/HEX display.

---
 rtl/key_search_ctrl_if.sv | 28 ++
 rtl/key_search_ctrl.sv | 144 ++++++++++++++
 tb/tb_key_search_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_search_ctrl_if.sv
// Port bundle of the key search controller: start/status, RC4 decoder handshake and decrypted-RAM read port.
// master = controller side, slave = decoder/RAM/top-level side.
interface key_search_ctrl_if #(
   parameter int KEY_WIDTH  = 24,
   parameter int ADDR_WIDTH = 5
) ();
   logic                  start;
   logic [KEY_WIDTH-1:0]  secret_key;
   logic                  decode_start;
   logic                  decode_done;
   logic [ADDR_WIDTH-1:0] msg_addr;
   logic [7:0]            msg_rdata;
   logic                  busy;
   logic                  found;
   logic                  not_found;
   logic [KEY_WIDTH-1:0]  key_found;
   logic [31:0]           perf_cycles;

   modport master (
      input  start, decode_done, msg_rdata,
      output secret_key, decode_start, msg_addr, busy, found, not_found, key_found, perf_cycles
   );

   modport slave (
      output start, decode_done, msg_rdata,
      input  secret_key, decode_start, msg_addr, busy, found, not_found, key_found, perf_cycles
   );
endinterface

// File: rtl/key_search_ctrl.sv
// Brute-force RC4 key search: launch decoder, check MSG_LEN bytes at 2 cycles/byte with early abort; start ignored while busy.
// Define KEY_SEARCH_PERF_CNT_EN to build the saturating busy-cycle counter on perf_cycles (tied to 0 otherwise).
module key_search_ctrl #(
   parameter int                   KEY_WIDTH  = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_MIN    = KEY_WIDTH'(24'h000000),
   parameter logic [KEY_WIDTH-1:0] KEY_MAX    = KEY_WIDTH'(24'h3FFFFF),
   parameter int                   MSG_LEN    = 32,
   parameter int                   ADDR_WIDTH = 5
) (
   input logic             clk,
   input logic             reset,
   key_search_ctrl_if.master ctrl
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MSG_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_DEC,
      S_RD_WAIT,
      S_CHECK,
      S_NEXT_KEY
   } state_t;

   state_t                state_q, state_d;
   logic [KEY_WIDTH-1:0]  key_q, key_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  busy_q, busy_d;
   logic                  found_q, found_d;
   logic                  not_found_q, not_found_d;
   logic [KEY_WIDTH-1:0]  key_found_q, key_found_d;
   logic                  byte_ok;

   // Legal plaintext is lowercase letters and space only.
   assign byte_ok = (ctrl.msg_rdata == 8'd32) ||
                    ((ctrl.msg_rdata >= 8'd97) && (ctrl.msg_rdata <= 8'd122));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         found_q     <= 1'b0;
         not_found_q <= 1'b0;
         key_found_q <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         addr_q      <= addr_d;
         busy_q      <= busy_d;
         found_q     <= found_d;
         not_found_q <= not_found_d;
         key_found_q <= key_found_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      addr_d      = addr_q;
      busy_d      = busy_q;
      found_d     = found_q;
      not_found_d = not_found_q;
      key_found_d = key_found_q;
      case (state_q)
         S_IDLE: begin
            if (ctrl.start) begin
               key_d       = KEY_MIN;
               found_d     = 1'b0;
               not_found_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = S_LAUNCH;
            end
         end
         S_LAUNCH:   state_d = S_WAIT_DEC;
         S_WAIT_DEC: begin
            if (ctrl.decode_done) begin
               addr_d  = '0;
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT:  state_d = S_CHECK;
         S_CHECK: begin
            if (!byte_ok) begin
               state_d = S_NEXT_KEY;
            end else if (addr_q == LAST_ADDR) begin
               key_found_d = key_q;
               found_d     = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = S_RD_WAIT;
            end
         end
         S_NEXT_KEY: begin
            // Range end is terminal; the key never wraps past KEY_MAX.
            if (key_q == KEY_MAX) begin
               not_found_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else begin
               key_d   = key_q + 1'b1;
               state_d = S_LAUNCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ctrl.secret_key   = key_q;
   assign ctrl.decode_start = (state_q == S_LAUNCH);
   assign ctrl.msg_addr     = addr_q;
   assign ctrl.busy         = busy_q;
   assign ctrl.found        = found_q;
   assign ctrl.not_found    = not_found_q;
   assign ctrl.key_found    = key_found_q;

`ifdef KEY_SEARCH_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if ((state_q == S_IDLE) && ctrl.start) begin
         perf_d = '0;
      end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign ctrl.perf_cycles = perf_q;
`else
   assign ctrl.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_key_search_ctrl.sv
// Randomized scoreboard bench for key_search_ctrl with behavioural decoder/RAM models.
// Expected launches and outcomes are queued at start; a negedge monitor pops and compares.
module tb_key_search_ctrl;
   localparam int              KW    = 24;
   localparam int              AW    = 5;
   localparam int              ML    = 32;
   localparam logic [KW-1:0]   KMIN  = 24'h000000;
   localparam logic [KW-1:0]   KMAX  = 24'h000003;
   localparam int              NKEYS = 4;

   typedef struct {
      logic [KW-1:0] key;
      int            max_addr;
   } launch_t;

   typedef struct {
      logic          found;
      logic          not_found;
      logic [KW-1:0] key_found;
      logic [KW-1:0] final_key;
   } result_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_s = 1'b0;
   logic dec_done_m = 1'b0;
   logic stray_done = 1'b0;
   logic dec_real = 1'b0;
   logic [1:0] ram_key = 2'd0;
   logic [7:0] msg_mem [NKEYS][ML];

   int checks = 0;
   int errors = 0;
   int searches_done = 0;
   int rst_epoch = 0;
   logic [KW-1:0] model_key_found = '0;
   launch_t exp_launch_q[$];
   result_t exp_result_q[$];

   always #5 clk = ~clk;

   key_search_ctrl_if #(.KEY_WIDTH(KW), .ADDR_WIDTH(AW)) ifc ();

   key_search_ctrl #(
      .KEY_WIDTH (KW),
      .KEY_MIN   (KMIN),
      .KEY_MAX   (KMAX),
      .MSG_LEN   (ML),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .ctrl (ifc)
   );

   assign ifc.start       = start_s;
   assign ifc.decode_done = dec_done_m | stray_done;

   always @(posedge clk) ifc.msg_rdata <= msg_mem[ram_key][ifc.msg_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit is_legal(input logic [7:0] b);
      return (b == " ") || (b >= "a" && b <= "z");
   endfunction

   function automatic logic [7:0] rand_valid();
      int r;
      r = $urandom_range(0, 26);
      return (r == 26) ? 8'd32 : 8'(97 + r);
   endfunction

   function automatic logic [7:0] rand_invalid();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      while (is_legal(b)) b = 8'($urandom_range(0, 255));
      return b;
   endfunction

   task automatic fill_key(input int k, input bit good);
      for (int i = 0; i < ML; i++) msg_mem[k][i] = rand_valid();
      if (!good) msg_mem[k][$urandom_range(0, ML - 1)] = rand_invalid();
   endtask

   // Reference: walk the key range, first fully legal message wins.
   task automatic model_search();
      result_t res;
      launch_t l;
      int      bad;
      res.found     = 1'b0;
      res.not_found = 1'b1;
      res.final_key = KMAX;
      for (int k = int'(KMIN); k <= int'(KMAX); k++) begin
         bad = -1;
         for (int i = 0; i < ML; i++) if (bad < 0 && !is_legal(msg_mem[k][i])) bad = i;
         l.key      = KW'(k);
         l.max_addr = (bad < 0) ? ML - 1 : bad;
         exp_launch_q.push_back(l);
         if (bad < 0) begin
            res.found       = 1'b1;
            res.not_found   = 1'b0;
            res.final_key   = KW'(k);
            model_key_found = KW'(k);
            break;
         end
      end
      res.key_found = model_key_found;
      exp_result_q.push_back(res);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start_s = 1'b1;
      @(posedge clk); #1 start_s = 1'b0;
   endtask

   task automatic do_search(input bit stray);
      int tgt;
      int n;
      tgt = searches_done + 1;
      model_search();
      pulse_start();
      if (stray) begin
         n = 0;
         while (!(ifc.msg_addr == 5'd3 && ifc.busy) && n < 2000) begin
            @(posedge clk); #1; n++;
         end
         if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL stray_wait: got timeout expected msg_addr 3");
         end
         @(posedge clk); #1 start_s = 1'b1; stray_done = 1'b1;
         @(posedge clk); #1 start_s = 1'b0; stray_done = 1'b0;
      end
      n = 0;
      while (searches_done < tgt && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 5000) begin
         checks++; errors++;
         $display("FAIL search_timeout: got no completion expected completion");
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Decoder model: fixed-random latency, then a single done pulse.
   initial begin
      logic [KW-1:0] kc;
      int            ep;
      int            d;
      forever begin
         @(negedge clk);
         if (ifc.decode_start === 1'b1) begin
            kc = ifc.secret_key;
            ep = rst_epoch;
            d  = $urandom_range(1, 6);
            repeat (d) @(posedge clk);
            #1 dec_done_m = 1'b1; dec_real = 1'b1; ram_key = kc[1:0];
            @(posedge clk);
            #1 dec_done_m = 1'b0; dec_real = 1'b0;
            if (ep == rst_epoch) chk("key_stable", ifc.secret_key, kc);
         end
      end
   end

   // Monitor: pops expected launches/results as the DUT presents them.
   initial begin
      bit      busy_prev;
      bit      tracking;
      bit      have_cur;
      int      max_seen;
      int      busy_cnt;
      launch_t cur;
      result_t r;
      busy_prev = 1'b0; tracking = 1'b0; have_cur = 1'b0; max_seen = 0; busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            busy_prev = 1'b0; tracking = 1'b0; have_cur = 1'b0;
         end else begin
            if (ifc.busy && !busy_prev) begin
               busy_cnt = 0;
               chk("perf_clear", ifc.perf_cycles, 0);
            end
            if (ifc.busy) busy_cnt++;
            if (tracking && int'(ifc.msg_addr) > max_seen) max_seen = int'(ifc.msg_addr);
            if (ifc.decode_start || (busy_prev && !ifc.busy)) begin
               if (have_cur) begin
                  if (!tracking) max_seen = -1;
                  chk("bytes_read", max_seen, cur.max_addr);
               end
               tracking = 1'b0; have_cur = 1'b0;
            end
            if (ifc.decode_start) begin
               if (exp_launch_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_launch: got decode_start key %0h expected none", ifc.secret_key);
               end else begin
                  cur = exp_launch_q.pop_front();
                  have_cur = 1'b1;
                  chk("launch_key", ifc.secret_key, cur.key);
               end
            end
            if (ifc.decode_done && dec_real && ifc.busy) begin
               tracking = 1'b1;
               max_seen = 0;
            end
            if (busy_prev && !ifc.busy) begin
               if (exp_result_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_end: got search end expected none");
               end else begin
                  r = exp_result_q.pop_front();
                  chk("found", ifc.found, r.found);
                  chk("not_found", ifc.not_found, r.not_found);
                  chk("key_found", ifc.key_found, r.key_found);
                  chk("final_key", ifc.secret_key, r.final_key);
`ifdef KEY_SEARCH_PERF_CNT_EN
                  chk("perf_cycles", ifc.perf_cycles, busy_cnt);
`else
                  chk("perf_cycles", ifc.perf_cycles, 0);
`endif
               end
               searches_done++;
            end
            busy_prev = ifc.busy;
         end
      end
   end

   initial begin
      string s;
      int    n;
      for (int k = 0; k < NKEYS; k++) fill_key(k, 1'b1);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", ifc.busy, 0);
      chk("rst_found", ifc.found, 0);
      chk("rst_not_found", ifc.not_found, 0);
      chk("rst_secret_key", ifc.secret_key, 0);
      chk("rst_key_found", ifc.key_found, 0);
      chk("rst_msg_addr", ifc.msg_addr, 0);
      chk("rst_decode_start", ifc.decode_start, 0);
      chk("rst_perf", ifc.perf_cycles, 0);
      reset = 1'b0;

      // Reset mid-WAIT_DEC; the decoder's late done must not wake the DUT.
      for (int k = 0; k < NKEYS; k++) fill_key(k, 1'b0);
      model_search();
      pulse_start();
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (ifc.decode_start !== 1'b1 && n < 50);
      @(posedge clk); #1 rst_epoch++; reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", ifc.busy, 0);
      chk("midrst_secret_key", ifc.secret_key, 0);
      chk("midrst_found", ifc.found, 0);
      chk("midrst_decode_start", ifc.decode_start, 0);
      reset = 1'b0;
      exp_launch_q.delete();
      exp_result_q.delete();
      model_key_found = '0;
      repeat (12) @(posedge clk);
      #1 chk("postrst_busy", ifc.busy, 0);

      // Key 2 carries the plaintext; keys 0 and 1 fail on byte 0.
      s = "the quick brown fox jumps over a";
      for (int k = 0; k < NKEYS; k++) fill_key(k, 1'b1);
      msg_mem[0][0] = 8'hFF;
      msg_mem[1][0] = 8'hFF;
      for (int i = 0; i < ML; i++) msg_mem[2][i] = s[i];
      do_search(1'b0);

      // Every key fails on the last byte: range exhausted, no wrap.
      for (int k = 0; k < NKEYS; k++) begin
         fill_key(k, 1'b1);
         msg_mem[k][ML - 1] = 8'd65;
      end
      do_search(1'b0);

      // Just-outside-range bytes at address 17, range-edge bytes that must pass.
      for (int k = 0; k < NKEYS; k++) fill_key(k, 1'b1);
      msg_mem[0][17] = 8'd96;
      msg_mem[1][17] = 8'd123;
      msg_mem[2][0]  = 8'd32;
      msg_mem[2][1]  = 8'd97;
      msg_mem[2][2]  = 8'd122;
      do_search(1'b0);

      // Stray start and decode_done during the byte check.
      for (int k = 0; k < NKEYS; k++) fill_key(k, 1'b1);
      do_search(1'b1);

      for (int r = 0; r < 15; r++) begin
         for (int k = 0; k < NKEYS; k++) fill_key(k, $urandom_range(0, 2) == 0);
         do_search(1'b0);
      end

      chk("launch_q_empty", exp_launch_q.size(), 0);
      chk("result_q_empty", exp_result_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
